// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - sequential register-file read-out engine streaming indexed words
module regfile_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_reg,
  input  logic [AW-1:0] last_reg,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_rd_addr;
  logic [AW-1:0] r_last_reg;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [AW-1:0] r_out_index;
  logic          r_out_last;
  logic          r_done;
  logic          w_busy;
  logic          w_load;
  logic          w_accept;
  logic          w_at_last;
  logic [AW-1:0] w_addr_inc;

  // A new word may enter the output register when it is empty or being drained this cycle.
  assign w_load     = (r_state == S_READ) && (!r_out_valid || out_ready);
  assign w_accept   = r_out_valid && out_ready;
  assign w_at_last  = (r_rd_addr == r_last_reg);
  assign w_addr_inc = (r_rd_addr == AW'(NREGS - 1)) ? '0 : r_rd_addr + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: walk READ until the last index is loaded, then DRAIN until it is accepted.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  if (w_load && w_at_last) w_next = S_DRAIN;
      S_DRAIN: if (w_accept) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // State-derived outputs.
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Read-address walk, output word register and done pulse.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_rd_addr   <= '0;
      r_last_reg  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else if (abort) begin
      // rd_addr and the data/index fields are left as they are; only the handshake is dropped.
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && w_accept;
      if ((r_state == S_IDLE) && start) begin
        r_rd_addr  <= first_reg;
        r_last_reg <= last_reg;
      end
      if (w_load) begin
        // rd_data is sampled at this edge, so a same-edge register-file write is not seen.
        r_out_data  <= rd_data;
        r_out_index <= r_rd_addr;
        r_out_last  <= w_at_last;
        r_out_valid <= 1'b1;
        if (!w_at_last) begin
          r_rd_addr <= w_addr_inc;
        end
      end else if (w_accept) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign rd_addr   = r_rd_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign busy      = w_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // register file model: combinational read, write at the rising edge
  logic [31:0] regs [32];
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  logic [4:0]  cap_idx  [64];
  logic [31:0] cap_data [64];
  logic        cap_last [64];
  int          cap_n;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  always @(posedge clk) begin
    if (we) regs[waddr] <= wdata;
  end

  regfile_dump_reader dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Must be called at a negedge. Returns the number of edges after the start edge
  // at which done was first seen high (-1 on timeout).
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int bp,
                          input int restart_k, input int wr_k, output int done_k);
    logic [6:0]  pat;
    int          p;
    logic        stall;
    logic [31:0] s_data;
    logic [4:0]  s_idx;
    logic        s_last;
    pat = 7'b1101001;
    p = 0;
    stall = 1'b0;
    s_data = '0;
    s_idx = '0;
    s_last = 1'b0;
    cap_n = 0;
    done_k = -1;
    first_reg = f;
    last_reg = l;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin
        done_k = k;
        break;
      end
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== s_data || out_index !== s_idx || out_last !== s_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%h i=%0d l=%0b expected v=1 d=%h i=%0d l=%0b",
                   out_valid, out_data, out_index, out_last, s_data, s_idx, s_last);
        end
      end
      we = 1'b0;
      if (k == restart_k) begin
        start = 1'b1;
        first_reg = 5'd10;
        last_reg = 5'd12;
      end else begin
        start = 1'b0;
      end
      if (k == wr_k) begin
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'hDEADBEEF;
      end
      out_ready = 1'b1;
      if (bp != 0 && out_valid && p < 7) out_ready = pat[p];
      if (out_valid) p++;
      stall = out_valid && !out_ready;
      s_data = out_data;
      s_idx = out_index;
      s_last = out_last;
      if (out_valid && out_ready && cap_n < 64) begin
        cap_idx[cap_n] = out_index;
        cap_data[cap_n] = out_data;
        cap_last[cap_n] = out_last;
        cap_n++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    we = 1'b0;
  endtask

  task automatic check_words(input string name, input logic [4:0] f, input int n, input logic [4:0] l);
    logic [4:0] idx;
    checks++;
    if (cap_n !== n) begin
      errors++;
      $display("FAIL %s_count: got %0d expected %0d", name, cap_n, n);
    end
    for (int i = 0; i < n && i < cap_n; i++) begin
      idx = f + 5'(i);
      checks++;
      if (cap_idx[i] !== idx || cap_data[i] !== 32'hA5A50000 + 32'(idx) || cap_last[i] !== (idx == l)) begin
        errors++;
        $display("FAIL %s_word%0d: got i=%0d d=%h l=%0b expected i=%0d d=%h l=%0b", name, i,
                 cap_idx[i], cap_data[i], cap_last[i], idx, 32'hA5A50000 + 32'(idx), (idx == l));
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_index !== 5'd0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%0b d=%h i=%0d l=%0b busy=%0b done=%0b a=%0d expected all 0",
               out_valid, out_data, out_index, out_last, busy, done, rd_addr);
    end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b v=%0b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_full_dump();
    int dk;
    @(negedge clk);
    first_reg = 5'd0;
    last_reg = 5'd31;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || rd_addr !== 5'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_latency: got busy=%0b a=%0d v=%0b expected 1 0 0", busy, rd_addr, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_index !== 5'd0 || out_data !== 32'hA5A50000) begin
      errors++;
      $display("FAIL full_first_word: got v=%0b i=%0d d=%h expected 1 0 a5a50000", out_valid, out_index, out_data);
    end
    // let it complete (out_ready=1) and start the measured dump
    repeat (40) @(negedge clk);
    run_dump(5'd0, 5'd31, 0, -1, -1, dk);
    check_words("full", 5'd0, 32, 5'd31);
    checks++;
    if (dk !== 33 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_done_time: got edge=%0d busy=%0b expected 33 0", dk, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL full_done_width: got %0b expected 0", done);
    end
  endtask

  task automatic test_wrap_single();
    int dk;
    @(negedge clk);
    run_dump(5'd30, 5'd1, 0, -1, -1, dk);
    check_words("wrap", 5'd30, 4, 5'd1);
    checks++;
    if (dk !== 5) begin
      errors++;
      $display("FAIL wrap_done_time: got %0d expected 5", dk);
    end
    @(negedge clk);
    run_dump(5'd7, 5'd7, 0, -1, -1, dk);
    check_words("single", 5'd7, 1, 5'd7);
    checks++;
    if (dk !== 2) begin
      errors++;
      $display("FAIL single_done_time: got %0d expected 2", dk);
    end
  endtask

  task automatic test_backpressure();
    int dk;
    @(negedge clk);
    run_dump(5'd0, 5'd3, 1, -1, -1, dk);
    check_words("bp", 5'd0, 4, 5'd3);
    checks++;
    if (dk < 0) begin
      errors++;
      $display("FAIL bp_done: got timeout expected done");
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    first_reg = 5'd0;
    last_reg = 5'd31;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0 || rd_addr !== 5'd3) begin
      errors++;
      $display("FAIL abort_state: got v=%0b busy=%0b done=%0b l=%0b a=%0d expected 0 0 0 0 3",
               out_valid, busy, done, out_last, rd_addr);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: got done=%0b v=%0b expected 0 0", done, out_valid);
      end
    end
  endtask

  task automatic test_clr_mid();
    @(negedge clk);
    first_reg = 5'd0;
    last_reg = 5'd31;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_index !== 5'd0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0) begin
      errors++;
      $display("FAIL clr_async: got v=%0b d=%h i=%0d l=%0b busy=%0b done=%0b a=%0d expected all 0",
               out_valid, out_data, out_index, out_last, busy, done, rd_addr);
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL clr_no_done: got done=%0b busy=%0b expected 0 0", done, busy);
      end
    end
  endtask

  task automatic test_start_ignored();
    int dk;
    @(negedge clk);
    run_dump(5'd0, 5'd5, 0, 2, -1, dk);
    check_words("ignore", 5'd0, 6, 5'd5);
  endtask

  task automatic test_back_to_back();
    int dk;
    @(negedge clk);
    run_dump(5'd2, 5'd3, 0, -1, -1, dk);
    check_words("b2b_a", 5'd2, 2, 5'd3);
    run_dump(5'd20, 5'd22, 0, -1, -1, dk);
    check_words("b2b_b", 5'd20, 3, 5'd22);
    checks++;
    if (dk !== 4) begin
      errors++;
      $display("FAIL b2b_done_time: got %0d expected 4", dk);
    end
  endtask

  task automatic test_concurrent_write();
    int dk;
    @(negedge clk);
    run_dump(5'd4, 5'd6, 0, -1, 1, dk);
    check_words("cw_old", 5'd4, 3, 5'd6);
    @(negedge clk);
    run_dump(5'd5, 5'd5, 0, -1, -1, dk);
    checks++;
    if (cap_n !== 1 || cap_data[0] !== 32'hDEADBEEF || cap_idx[0] !== 5'd5) begin
      errors++;
      $display("FAIL cw_new: got n=%0d d=%h i=%0d expected 1 deadbeef 5", cap_n, cap_data[0], cap_idx[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA5A50000 + 32'(i);
    start = 1'b0;
    abort = 1'b0;
    first_reg = '0;
    last_reg = '0;
    out_ready = 1'b1;
    we = 1'b0;
    waddr = '0;
    wdata = '0;
    test_reset();
    test_full_dump();
    test_wrap_single();
    test_backpressure();
    test_abort();
    test_clr_mid();
    test_start_ignored();
    test_back_to_back();
    test_concurrent_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
